// File: rtl/video_in_pkg.sv
// Shared types and width helpers for the video_in capture front-end.
package video_in_pkg;

  typedef enum logic [1:0] {
    S_WAIT,
    S_VBLANK,
    S_HBLANK,
    S_LINE
  } state_t;

  // Sideband carried with every packed word through the output FIFO.
  typedef struct packed {
    logic sof;
    logic eol;
  } word_tag_t;

  localparam int unsigned DROP_W = 16;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to address depth entries.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/video_in_fifo.sv
// Synchronous FIFO with registered full/empty flags and a combinational head.
module video_in_fifo
  import video_in_pkg::*;
#(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/video_in_pack.sv
// Video capture front-end: frame/line geometry checking, pixel packing and
// buffered ready/valid output with sof/eol sideband and dropped-word count.
module video_in_pack
  import video_in_pkg::*;
#(
  parameter int unsigned P_WIDTH      = 640,
  parameter int unsigned P_HEIGHT     = 480,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned PIX_PER_WORD = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          pix_en,
  input  logic                          frame_valid,
  input  logic                          line_valid,
  input  logic [PIX_W-1:0]              pixel_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PIX_W*PIX_PER_WORD-1:0] out_data,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic                          err_line_long,
  output logic                          err_line_short,
  output logic                          err_frame_short,
  output logic                          err_frame_long,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int unsigned DW = PIX_W * PIX_PER_WORD;
  localparam int unsigned CW = cnt_w(P_WIDTH);
  localparam int unsigned RW = cnt_w(P_HEIGHT);
  localparam int unsigned LW = cnt_w(PIX_PER_WORD - 1);

  typedef struct packed {
    word_tag_t       tag;
    logic [DW-1:0]   data;
  } fifo_entry_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] lane;
  logic [DW-1:0] pack_q;
  logic [DW-1:0] pack_nxt;
  logic          push_q;
  fifo_entry_t   push_entry;
  fifo_entry_t   head_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic          do_cap;
  logic          word_done;
  logic [CW-1:0] cap_col;
  logic [LW-1:0] cap_lane;
  logic [RW-1:0] cap_row;
  logic          drop;

  // Outside a line the capture position is the start of a line, whatever col/lane hold.
  always_comb begin
    cap_col  = (state == S_LINE) ? col : '0;
    cap_lane = (state == S_LINE) ? lane : '0;
    cap_row  = (state == S_VBLANK) ? '0 : row;
    do_cap   = 1'b0;
    if (pix_en && frame_valid && line_valid) begin
      case (state)
        S_VBLANK: do_cap = 1'b1;
        S_HBLANK: do_cap = (row < RW'(P_HEIGHT));
        S_LINE:   do_cap = (col < CW'(P_WIDTH));
        default:  do_cap = 1'b0;
      endcase
    end
    word_done = (cap_lane == LW'(PIX_PER_WORD - 1));
    pack_nxt  = pack_q;
    for (int unsigned i = 0; i < PIX_PER_WORD; i++)
      if (LW'(i) == cap_lane)
        pack_nxt[DW-1-i*PIX_W -: PIX_W] = pixel_in;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state           <= S_WAIT;
      col             <= '0;
      row             <= '0;
      lane            <= '0;
      pack_q          <= '0;
      push_q          <= 1'b0;
      push_entry      <= '0;
      err_line_long   <= 1'b0;
      err_line_short  <= 1'b0;
      err_frame_short <= 1'b0;
      err_frame_long  <= 1'b0;
    end else begin
      push_q          <= 1'b0;
      err_line_long   <= 1'b0;
      err_line_short  <= 1'b0;
      err_frame_short <= 1'b0;
      err_frame_long  <= 1'b0;
      if (do_cap) begin
        pack_q <= pack_nxt;
        col    <= cap_col + 1'b1;
        lane   <= word_done ? '0 : cap_lane + 1'b1;
        if (word_done) begin
          push_q              <= 1'b1;
          push_entry.data     <= pack_nxt;
          push_entry.tag.sof  <= (cap_row == '0) && (cap_col == CW'(PIX_PER_WORD - 1));
          push_entry.tag.eol  <= (cap_col == CW'(P_WIDTH - 1));
        end
      end
      if (pix_en) begin
        case (state)
          S_WAIT:
            if (!frame_valid && !line_valid)
              state <= S_VBLANK;
          S_VBLANK:
            if (frame_valid) begin
              row   <= '0;
              state <= line_valid ? S_LINE : S_HBLANK;
            end
          S_HBLANK:
            if (frame_valid && line_valid) begin
              if (row < RW'(P_HEIGHT)) begin
                state <= S_LINE;
              end else begin
                err_frame_long <= 1'b1;
                state          <= S_WAIT;
              end
            end else if (!frame_valid) begin
              err_frame_short <= (row != RW'(P_HEIGHT));
              state           <= S_VBLANK;
            end
          S_LINE:
            if (frame_valid && line_valid) begin
              if (col == CW'(P_WIDTH)) begin
                err_line_long <= 1'b1;
                state         <= S_WAIT;
              end
            end else if (frame_valid) begin
              if (col == CW'(P_WIDTH)) begin
                row   <= row + 1'b1;
                col   <= '0;
                state <= S_HBLANK;
              end else begin
                err_line_short <= 1'b1;
                state          <= S_WAIT;
              end
            end else begin
              err_line_short <= 1'b1;
              state          <= S_VBLANK;
            end
          default: state <= S_WAIT;
        endcase
      end
    end
  end

  video_in_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .RST       (RST),
    .push      (push_q),
    .push_data (push_entry),
    .pop       (out_ready),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head_entry.data : '0;
  assign out_sof   = out_valid && head_entry.tag.sof;
  assign out_eol   = out_valid && head_entry.tag.eol;

  assign drop = push_q && fifo_full && !(out_ready && out_valid);

  always_ff @(posedge clk) begin
    if (RST)
      drop_cnt <= '0;
    else if (drop && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 1'b1;
  end

endmodule

// File: tb/tb_video_in_pack.sv
// Bench for video_in_pack: frame-level model of expected words and error pulses.
module tb_video_in_pack;

  localparam int W     = 32;
  localparam int H     = 6;
  localparam int PW    = 8;
  localparam int PPW   = 4;
  localparam int DEPTH = 4;
  localparam int DW    = PW * PPW;

  logic          clk = 1'b0;
  logic          RST;
  logic          pix_en;
  logic          frame_valid;
  logic          line_valid;
  logic [PW-1:0] pixel_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          err_line_long;
  logic          err_line_short;
  logic          err_frame_short;
  logic          err_frame_long;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  video_in_pack #(
    .P_WIDTH      (W),
    .P_HEIGHT     (H),
    .PIX_W        (PW),
    .PIX_PER_WORD (PPW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk             (clk),
    .RST             (RST),
    .pix_en          (pix_en),
    .frame_valid     (frame_valid),
    .line_valid      (line_valid),
    .pixel_in        (pixel_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_sof         (out_sof),
    .out_eol         (out_eol),
    .err_line_long   (err_line_long),
    .err_line_short  (err_line_short),
    .err_frame_short (err_frame_short),
    .err_frame_long  (err_frame_long),
    .drop_cnt        (drop_cnt)
  );

  typedef struct {
    logic          sof;
    logic          eol;
    logic [DW-1:0] data;
  } word_t;

  word_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            exp_ll = 0, exp_ls = 0, exp_fs = 0, exp_fl = 0;
  int            obs_ll = 0, obs_ls = 0, obs_fs = 0, obs_fl = 0;
  int            exp_drop = 0;
  int            gap = 0;
  bit            got_first = 0;
  bit            got_eol = 0;
  logic [DW-1:0] first_data = '0;
  logic          first_sof = 1'b0;
  logic [DW-1:0] first_eol_data = '0;
  bit            prev_stall = 0;
  logic [DW+1:0] prev_word = '0;

  function automatic logic [PW-1:0] pix(input int f, input int r, input int c);
    return PW'((c + 1 + r * 40 + f * 7) % 256);
  endfunction

  // Queue the word whose last pixel is column cend; a stalled consumer bounds what the FIFO keeps.
  task automatic exp_push(input int f, input int r, input int cend);
    word_t e;
    int    c0;
    c0     = cend - PPW + 1;
    e.data = '0;
    for (int k = 0; k < PPW; k++)
      e.data = {e.data[DW-PW-1:0], pix(f, r, c0 + k)};
    e.sof = (r == 0) && (c0 == 0);
    e.eol = (cend == W - 1);
    if (!out_ready && exp_q.size() >= DEPTH)
      exp_drop++;
    else
      exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic cyc(input logic en, input logic fv, input logic lv, input logic [PW-1:0] p);
    pix_en      = en;
    frame_valid = fv;
    line_valid  = lv;
    pixel_in    = p;
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic fv, input logic lv, input logic [PW-1:0] p);
    repeat (gap) cyc(1'b0, 1'($urandom), 1'($urandom), PW'($urandom));
    cyc(1'b1, fv, lv, p);
  endtask

  // One frame: nrows lines of W pixels, except bad_row which has bad_len pixels
  // (and, when cut, ends the frame mid-line). direct skips the leading hblank sample.
  task automatic frame(input int f, input int nrows, input int bad_row, input int bad_len,
                       input bit cut, input bit direct);
    bit alive;
    int len;
    alive = 1;
    samp(0, 0, 0);
    samp(0, 0, 0);
    if (!direct) samp(1, 0, 0);
    for (int r = 0; r < nrows; r++) begin
      len = (r == bad_row) ? bad_len : W;
      if (alive && r == H) begin
        exp_fl++;
        alive = 0;
      end
      for (int c = 0; c < len; c++) begin
        samp(1, 1, pix(f, r, c));
        if (alive && c < W && (c % PPW) == PPW - 1) exp_push(f, r, c);
      end
      if (alive && len > W) begin
        exp_ll++;
        alive = 0;
      end
      if (cut && r == bad_row) begin
        if (alive) exp_ls++;
        alive = 0;
        break;
      end
      samp(1, 0, 0);
      if (alive && len < W) begin
        exp_ls++;
        alive = 0;
      end
      samp(1, 0, 0);
    end
    if (alive && nrows != H) exp_fs++;
    samp(0, 0, 0);
    samp(0, 0, 0);
  endtask

  task automatic drain_and_check(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0);
    chk({tag, "_pending_words"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_out_valid_idle"}, 64'(out_valid), 64'd0);
    chk({tag, "_err_line_long"}, 64'(obs_ll), 64'(exp_ll));
    chk({tag, "_err_line_short"}, 64'(obs_ls), 64'(exp_ls));
    chk({tag, "_err_frame_short"}, 64'(obs_fs), 64'(exp_fs));
    chk({tag, "_err_frame_long"}, 64'(obs_fl), 64'(exp_fl));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
  endtask

  always @(negedge clk) begin
    word_t e;
    if (RST !== 1'b0) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if ({out_sof, out_eol, out_data} !== prev_word) begin
          errors++;
          $display("FAIL head_stable: got %h, required %h", {out_sof, out_eol, out_data}, prev_word);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%h sof=%b eol=%b, required no word",
                   out_data, out_sof, out_eol);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_sof !== e.sof || out_eol !== e.eol) begin
            errors++;
            $display("FAIL word: got data=%h sof=%b eol=%b, required data=%h sof=%b eol=%b",
                     out_data, out_sof, out_eol, e.data, e.sof, e.eol);
          end
        end
        if (!got_first) begin
          got_first  = 1;
          first_data = out_data;
          first_sof  = out_sof;
        end
        if (out_eol && !got_eol) begin
          got_eol        = 1;
          first_eol_data = out_data;
        end
      end
      if (err_line_long)   obs_ll++;
      if (err_line_short)  obs_ls++;
      if (err_frame_short) obs_fs++;
      if (err_frame_long)  obs_fl++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_sof, out_eol, out_data};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST       = 1'b1;
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset_errs", 64'({err_line_long, err_line_short, err_frame_short, err_frame_long}), 64'd0);
    RST = 1'b0;

    // Clean frame, then literal pins on the first word and the first end-of-line word.
    frame(0, H, -1, 0, 0, 0);
    drain_and_check("t1");
    chk("first_word_data", 64'(first_data), 64'h01020304);
    chk("first_word_sof", 64'(first_sof), 64'd1);
    chk("first_eol_data", 64'(first_eol_data), 64'h1D1E1F20);

    // Line starting straight out of vertical blanking.
    frame(1, H, -1, 0, 0, 1);
    drain_and_check("t2");

    // Over-long line, then recovery on the following frame.
    frame(2, H, 2, W + 1, 0, 0);
    frame(3, H, -1, 0, 0, 0);
    drain_and_check("t3");

    // Short line, short frame, frame dropped mid-line, over-tall frame.
    frame(4, H, 1, W - 1, 0, 0);
    frame(5, H - 1, -1, 0, 0, 0);
    frame(6, H, 3, 10, 1, 0);
    frame(7, H + 1, -1, 0, 0, 0);
    drain_and_check("t4");

    // Consumer stalled for a whole line: FIFO holds DEPTH words, the rest are dropped.
    out_ready = 1'b0;
    frame(8, 1, -1, 0, 0, 0);
    chk("stall_drop_cnt", 64'(drop_cnt), 64'd4);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_head_sof", 64'(out_sof), 64'd1);
    out_ready = 1'b1;
    drain_and_check("t5");

    // Reset mid-line with words held, then a slow pixel strobe.
    out_ready = 1'b0;
    samp(0, 0, 0);
    samp(0, 0, 0);
    samp(1, 0, 0);
    for (int c = 0; c < 10; c++) samp(1, 1, pix(9, 0, c));
    repeat (3) cyc(1'b0, 1'b1, 1'b1, '0);
    RST = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, '0);
    RST = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_drop_cnt", 64'(drop_cnt), 64'd0);
    out_ready = 1'b1;
    gap = 3;
    for (int c = 10; c < W; c++) samp(1, 1, pix(9, 0, c));
    samp(1, 0, 0);
    samp(1, 0, 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, '0);
    chk("no_capture_before_blank", 64'(out_valid), 64'd0);
    frame(0, H, -1, 0, 0, 0);
    drain_and_check("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
